// File: rtl/ones_word_gen.sv
// Builds a 2**log_bit_width-bit word holding a requested number of contiguous ones,
// starting at a given bit and wrapping past the MSB; one bit is decided per clock.
module ones_word_gen #(
    parameter int log_bit_width = 5,
    localparam int N = 1 << log_bit_width
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [log_bit_width:0] count_in,
    input  logic [log_bit_width-1:0] offset_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           word_out,
    output logic                   sat_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [log_bit_width:0] full_count = (log_bit_width + 1)'(N);

    state_t                   state;
    logic [log_bit_width:0]   cnt;
    logic [log_bit_width-1:0] offset;
    logic [log_bit_width-1:0] idx;
    logic                     sat;
    logic [N-1:0]             acc;

    logic [log_bit_width-1:0] pos;
    logic [N-1:0]             acc_next;
    logic                     last;

    // Bit position wraps naturally in log_bit_width bits, giving the mod-N rotation.
    always_comb begin
        pos      = offset + idx;
        acc_next = acc;
        if ({1'b0, idx} < cnt) begin
            acc_next[pos] = 1'b1;
        end
        last     = &idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            word_out  <= '0;
            sat_flag  <= 1'b0;
            cnt       <= '0;
            offset    <= '0;
            idx       <= '0;
            sat       <= 1'b0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt      <= (count_in > full_count) ? full_count : count_in;
                        sat      <= (count_in > full_count);
                        offset   <= offset_in;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUILD;
                    end
                end
                BUILD: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (last) begin
                        word_out  <= acc_next;
                        sat_flag  <= sat;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ones_word_gen.sv
// Directed bench for ones_word_gen: transaction-level reference model checked every
// cycle, plus literal expectations for latency and result words.
module tb_ones_word_gen;

    localparam int LBW = 5;
    localparam int N   = 1 << LBW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [LBW:0]   count_in = '0;
    logic [LBW-1:0] offset_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N-1:0]   word_out;
    logic           sat_flag;

    int checks   = 0;
    int failures = 0;

    ones_word_gen #(.log_bit_width(LBW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .count_in (count_in),
        .offset_in(offset_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .word_out (word_out),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    // Expected word: a run of min(c,N) ones rotated left by off.
    function automatic logic [31:0] ref_word(int c, int off);
        logic [63:0] m;
        logic [63:0] r;
        if (c >= N) return 32'hFFFF_FFFF;
        m = (64'd1 << c) - 64'd1;
        r = m << off;
        return r[31:0] | r[63:32];
    endfunction

    // Reference model at transaction level: an accepted request becomes visible N edges later.
    int          cyc = 0;
    logic        m_idle = 1'b1;
    logic        m_done = 1'b0;
    logic [31:0] m_word = '0;
    logic        m_sat = 1'b0;
    int          m_due = -1;
    logic [31:0] m_pend_word = '0;
    logic        m_pend_sat = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idle = 1'b1;
            m_done = 1'b0;
            m_word = '0;
            m_sat  = 1'b0;
            m_due  = -1;
        end else begin
            cyc++;
            if (m_idle) begin
                if (in_valid) begin
                    m_idle      = 1'b0;
                    m_due       = cyc + N;
                    m_pend_word = ref_word(int'(count_in), int'(offset_in));
                    m_pend_sat  = (int'(count_in) > N);
                end
            end else if (!m_done) begin
                if (cyc == m_due) begin
                    m_done = 1'b1;
                    m_word = m_pend_word;
                    m_sat  = m_pend_sat;
                end
            end else if (out_ready) begin
                m_done = 1'b0;
                m_idle = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_in_ready", 32'(in_ready), 32'(m_idle));
        chk("model_out_valid", 32'(out_valid), 32'(m_done));
        chk("model_word_out", word_out, m_word);
        chk("model_sat_flag", 32'(sat_flag), 32'(m_sat));
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) chk({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Returns the number of edges after the accept edge at which out_valid was first seen.
    task automatic accept_and_wait(input int c, input int off, input string name, output int lat);
        wait_ready(name);
        count_in  = (LBW + 1)'(c);
        offset_in = LBW'(off);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input int c, input int off, input logic [31:0] exp_w,
                       input logic exp_s, input string name);
        int lat;
        accept_and_wait(c, off, name, lat);
        chk({name, "_latency"}, 32'(lat), 32'(N));
        chk({name, "_word"}, word_out, exp_w);
        chk({name, "_sat"}, 32'(sat_flag), 32'(exp_s));
        release_result();
        chk({name, "_back_to_idle"}, 32'(in_ready), 32'd1);
        chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int lat;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_word_out", word_out, 32'h0);
        chk("reset_sat_flag", 32'(sat_flag), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        chk("ref_5_0", ref_word(5, 0), 32'h0000_001F);
        chk("ref_4_30", ref_word(4, 30), 32'hC000_0003);
        chk("ref_40_3", ref_word(40, 3), 32'hFFFF_FFFF);
        chk("ref_0_13", ref_word(0, 13), 32'h0000_0000);

        run(5, 0, 32'h0000_001F, 1'b0, "c5_o0");
        run(4, 30, 32'hC000_0003, 1'b0, "c4_o30");
        run(32, 7, 32'hFFFF_FFFF, 1'b0, "c32_o7");
        run(40, 7, 32'hFFFF_FFFF, 1'b1, "c40_o7");
        run(0, 13, 32'h0000_0000, 1'b0, "c0_o13");
        run(31, 1, 32'hFFFF_FFFE, 1'b0, "c31_o1");
        run(63, 0, 32'hFFFF_FFFF, 1'b1, "c63_o0");
        run(1, 31, 32'h8000_0000, 1'b0, "c1_o31");

        // Backpressure: result held while a new request waits.
        accept_and_wait(8, 4, "bp", lat);
        chk("bp_latency", 32'(lat), 32'(N));
        chk("bp_word", word_out, 32'h0000_0FF0);
        held      = word_out;
        count_in  = 6'd3;
        offset_in = 5'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid_held", 32'(out_valid), 32'd1);
            chk("bp_word_stable", word_out, held);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_after_ready", 32'(in_ready), 32'd1);
        chk("bp_valid_dropped", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("bp2_latency", 32'(lat), 32'(N));
        chk("bp2_word", word_out, 32'h0000_0007);
        chk("bp2_word_not_stale", 32'(word_out != held), 32'd1);
        release_result();

        // Reset in the middle of a build: nothing produced, previous word cleared.
        run(6, 2, 32'h0000_00FC, 1'b0, "pre_rst");
        wait_ready("mid_rst");
        count_in  = 6'd20;
        offset_in = 5'd0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_word_out", word_out, 32'h0);
        chk("mid_rst_sat", 32'(sat_flag), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (N + 4) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) break;
        end
        chk("mid_rst_no_output", 32'(out_valid), 32'd0);
        run(3, 0, 32'h0000_0007, 1'b0, "post_rst");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
